// File: rtl/tag_fill_controller_if.sv
// Handshake and tag-table bundle between the cache front-end, the tag
// lookup table, the fill engine and the tag fill controller.
interface tag_fill_controller_if #(
    parameter int BW_ACCESS_ADDR     = 16,
    parameter int BW_CAPACITY_BLOCKS = 3
);
    typedef logic [BW_ACCESS_ADDR-1:0]     addr_t;
    typedef logic [BW_CAPACITY_BLOCKS-1:0] blk_t;

    logic  req_valid_i;
    logic  req_ready_o;
    addr_t req_addr_i;

    logic  rsp_valid_o;
    logic  rsp_ready_i;
    logic  rsp_hit_o;
    blk_t  rsp_cache_addr_o;

    logic  inv_valid_i;
    logic  inv_ready_o;
    addr_t inv_addr_i;

    logic  tlt_wren_o;
    logic  tlt_rmen_o;
    addr_t tlt_addr_search_o;
    addr_t tlt_addr_write_o;
    blk_t  tlt_cache_addr_o;
    addr_t tlt_addr_search_i;
    blk_t  tlt_cache_addr_search_i;
    logic  tlt_hit_i;

    logic  evict_req_o;
    logic  evict_ack_i;
    addr_t evict_addr_o;

    logic  fill_req_o;
    logic  fill_done_i;
    addr_t fill_addr_o;
    blk_t  fill_cache_addr_o;

    modport slave (
        input  req_valid_i, req_addr_i,
        output req_ready_o,
        output rsp_valid_o, rsp_hit_o, rsp_cache_addr_o,
        input  rsp_ready_i,
        input  inv_valid_i, inv_addr_i,
        output inv_ready_o,
        output tlt_wren_o, tlt_rmen_o, tlt_addr_search_o,
        output tlt_addr_write_o, tlt_cache_addr_o,
        input  tlt_addr_search_i, tlt_cache_addr_search_i, tlt_hit_i,
        output evict_req_o, evict_addr_o,
        input  evict_ack_i,
        output fill_req_o, fill_addr_o, fill_cache_addr_o,
        input  fill_done_i
    );

    modport master (
        output req_valid_i, req_addr_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_hit_o, rsp_cache_addr_o,
        output rsp_ready_i,
        output inv_valid_i, inv_addr_i,
        input  inv_ready_o,
        input  tlt_wren_o, tlt_rmen_o, tlt_addr_search_o,
        input  tlt_addr_write_o, tlt_cache_addr_o,
        output tlt_addr_search_i, tlt_cache_addr_search_i, tlt_hit_i,
        input  evict_req_o, evict_addr_o,
        output evict_ack_i,
        input  fill_req_o, fill_addr_o, fill_cache_addr_o,
        output fill_done_i
    );
endinterface

// File: rtl/tag_fill_controller.sv
// Lookup / evict / fill / tag-write sequencer for a set-associative tag
// table, with per-group round-robin victim choice and invalidation.
module tag_fill_controller #(
    parameter int BW_ACCESS_ADDR    = 16,
    parameter int N_WORDS_PER_BLOCK = 4,
    parameter int N_CAPACITY_BLOCKS = 8,
    parameter int ASSOCIATIVITY     = 2
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    tag_fill_controller_if.slave  bus
);
    localparam int BW_CAPACITY_BLOCKS = $clog2(N_CAPACITY_BLOCKS);
    localparam int BW_ACCESS_SET      = $clog2(ASSOCIATIVITY);
    localparam int BW_ACCESS_GROUP    = BW_CAPACITY_BLOCKS - BW_ACCESS_SET;
    localparam int BW_WORDS_PER_BLOCK = $clog2(N_WORDS_PER_BLOCK);
    localparam int N_GROUPS           = 1 << BW_ACCESS_GROUP;

    typedef logic [BW_ACCESS_ADDR-1:0]     addr_t;
    typedef logic [BW_CAPACITY_BLOCKS-1:0] blk_t;
    typedef logic [BW_ACCESS_SET-1:0]      way_t;

    localparam addr_t OFS_MASK = addr_t'(N_WORDS_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_WRITE,
        S_RESP,
        S_INV
    } state_t;

    state_t state_q, state_d;
    addr_t  addr_q, addr_d;
    addr_t  evict_addr_q, evict_addr_d;
    blk_t   blk_q, blk_d;
    logic   hit_q, hit_d;
    logic   rdy_q, rdy_d;
    logic   evict_req_q, evict_req_d;
    logic   fill_req_q, fill_req_d;
    logic   rsp_valid_q, rsp_valid_d;

    logic [N_CAPACITY_BLOCKS-1:0]       occ_q, occ_d;
    logic [N_GROUPS-1:0][BW_ACCESS_SET-1:0] rr_q, rr_d;

    logic [BW_ACCESS_GROUP-1:0] grp;
    blk_t                       victim;

    assign grp    = addr_q[BW_WORDS_PER_BLOCK +: BW_ACCESS_GROUP];
    assign victim = {rr_q[grp], grp};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        evict_addr_d = evict_addr_q;
        blk_d        = blk_q;
        hit_d        = hit_q;
        occ_d        = occ_q;
        rr_d         = rr_q;
        unique case (state_q)
            S_IDLE: begin
                // invalidation wins when both handshakes are offered
                if (rdy_q && bus.inv_valid_i) begin
                    addr_d  = bus.inv_addr_i;
                    state_d = S_INV;
                end else if (rdy_q && bus.req_valid_i) begin
                    addr_d  = bus.req_addr_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (bus.tlt_hit_i) begin
                    blk_d   = bus.tlt_cache_addr_search_i;
                    hit_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    blk_d = victim;
                    hit_d = 1'b0;
                    if (occ_q[victim]) begin
                        evict_addr_d = bus.tlt_addr_search_i & ~OFS_MASK;
                        state_d      = S_EVICT;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_EVICT: begin
                if (bus.evict_ack_i) state_d = S_FILL;
            end
            S_FILL: begin
                if (bus.fill_done_i) state_d = S_WRITE;
            end
            S_WRITE: begin
                occ_d[blk_q] = 1'b1;
                rr_d[grp]    = rr_q[grp] + way_t'(1);
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready_i) state_d = S_IDLE;
            end
            S_INV: begin
                if (bus.tlt_hit_i) occ_d[bus.tlt_cache_addr_search_i] = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdy_d       = (state_d == S_IDLE);
        evict_req_d = (state_d == S_EVICT);
        fill_req_d  = (state_d == S_FILL);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            evict_addr_q <= '0;
            blk_q        <= '0;
            hit_q        <= 1'b0;
            rdy_q        <= 1'b0;
            evict_req_q  <= 1'b0;
            fill_req_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            occ_q        <= '0;
            rr_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            evict_addr_q <= evict_addr_d;
            blk_q        <= blk_d;
            hit_q        <= hit_d;
            rdy_q        <= rdy_d;
            evict_req_q  <= evict_req_d;
            fill_req_q   <= fill_req_d;
            rsp_valid_q  <= rsp_valid_d;
            occ_q        <= occ_d;
            rr_q         <= rr_d;
        end
    end

    // tag-table strobes depend on the same-cycle search result
    always_comb begin
        bus.tlt_wren_o        = 1'b0;
        bus.tlt_rmen_o        = 1'b0;
        bus.tlt_addr_search_o = '0;
        bus.tlt_addr_write_o  = '0;
        bus.tlt_cache_addr_o  = '0;
        unique case (state_q)
            S_LOOKUP: begin
                bus.tlt_addr_search_o = addr_q;
                if (!bus.tlt_hit_i) begin
                    bus.tlt_cache_addr_o = victim;
                    bus.tlt_rmen_o       = occ_q[victim];
                end
            end
            S_WRITE: begin
                bus.tlt_wren_o       = 1'b1;
                bus.tlt_cache_addr_o = blk_q;
                bus.tlt_addr_write_o = addr_q;
            end
            S_INV: begin
                bus.tlt_addr_search_o = addr_q;
                if (bus.tlt_hit_i) begin
                    bus.tlt_rmen_o       = 1'b1;
                    bus.tlt_cache_addr_o = bus.tlt_cache_addr_search_i;
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready_o       = rdy_q & ~bus.inv_valid_i;
    assign bus.inv_ready_o       = rdy_q;
    assign bus.evict_req_o       = evict_req_q;
    assign bus.evict_addr_o      = evict_req_q ? evict_addr_q : '0;
    assign bus.fill_req_o        = fill_req_q;
    assign bus.fill_addr_o       = fill_req_q ? (addr_q & ~OFS_MASK) : '0;
    assign bus.fill_cache_addr_o = fill_req_q ? blk_q : '0;
    assign bus.rsp_valid_o       = rsp_valid_q;
    assign bus.rsp_hit_o         = rsp_valid_q & hit_q;
    assign bus.rsp_cache_addr_o  = rsp_valid_q ? blk_q : '0;
endmodule

// File: tb/tb_tag_fill_controller.sv
// Bench for tag_fill_controller: directed scenarios then random traffic,
// checked against a behavioural cache-directory model.
module tb_tag_fill_controller;
    localparam int AW = 16;
    localparam int NW = 4;
    localparam int NB = 8;
    localparam int AS = 2;
    localparam int BW = 3;
    localparam int NG = NB / AS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tag_fill_controller_if #(.BW_ACCESS_ADDR(AW), .BW_CAPACITY_BLOCKS(BW)) bus();

    tag_fill_controller #(
        .BW_ACCESS_ADDR(AW),
        .N_WORDS_PER_BLOCK(NW),
        .N_CAPACITY_BLOCKS(NB),
        .ASSOCIATIVITY(AS)
    ) dut (
        .clock_i(clk),
        .resetn_i(rst_n),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail = 0;

    // tag lookup table environment: synchronous write/remove, comb search
    logic [AW-1:0] tt_tag [NB];
    logic [NB-1:0] tt_val;
    logic          tt_hit;
    logic [BW-1:0] tt_blk;

    initial for (int i = 0; i < NB; i++) tt_tag[i] = '0;

    always_comb begin
        tt_hit = 1'b0;
        tt_blk = '0;
        for (int i = 0; i < NB; i++)
            if (tt_val[i] && tt_tag[i] == (bus.tlt_addr_search_o & 16'hfffc)) begin
                tt_hit = 1'b1;
                tt_blk = BW'(i);
            end
    end

    assign bus.tlt_hit_i = tt_hit;
    assign bus.tlt_cache_addr_search_i = tt_blk;
    assign bus.tlt_addr_search_i =
        tt_val[bus.tlt_cache_addr_o] ? tt_tag[bus.tlt_cache_addr_o] : '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            tt_val <= '0;
        end else if (bus.tlt_wren_o) begin
            tt_val[bus.tlt_cache_addr_o] <= 1'b1;
            tt_tag[bus.tlt_cache_addr_o] <= bus.tlt_addr_write_o & 16'hfffc;
        end else if (bus.tlt_rmen_o) begin
            tt_val[bus.tlt_cache_addr_o] <= 1'b0;
        end
    end

    // reference model: block contents and per-group fill counters
    bit            mv [NB];
    logic [AW-1:0] mt [NB];
    int            mrr [NG];

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            mv[i] = 0;
            mt[i] = '0;
        end
        for (int g = 0; g < NG; g++) mrr[g] = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic [AW-1:0] a, input int ew, input int fw, input int rw);
        bit ehit, eev, done, seen_e, seen_f;
        int eblk, g, lat_exp, cyc, lat, ec, fc, rc;
        int n_wren, n_rmen, rmen1, ready_hi, unstable, first_lat;
        logic [AW-1:0] base, eeaddr, o_eaddr, o_faddr, o_waddr;
        logic [BW-1:0] o_fblk, o_wblk, o_rblk;
        logic o_rhit;

        base = a & 16'hfffc;
        g = int'(a[3:2]);
        ehit = 0;
        eblk = 0;
        for (int i = 0; i < NB; i++)
            if (mv[i] && mt[i] == base) begin
                ehit = 1;
                eblk = i;
            end
        eev = 0;
        eeaddr = '0;
        if (!ehit) begin
            eblk = mrr[g] * NG + g;
            eev = mv[eblk];
            eeaddr = mt[eblk];
            mv[eblk] = 1;
            mt[eblk] = base;
            mrr[g] = (mrr[g] + 1) % AS;
        end
        lat_exp = ehit ? 2 : 2 + (eev ? ew + 1 : 0) + fw + 1 + 1;

        bus.req_addr_i = a;
        bus.req_valid_i = 1'b1;
        cyc = 0;
        while (bus.req_ready_o !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("req_accept", bus.req_ready_o, 1);
        tick();
        bus.req_valid_i = 1'b0;

        lat = 1; ec = 0; fc = 0; rc = 0;
        n_wren = 0; n_rmen = 0; rmen1 = 0; ready_hi = 0; unstable = 0;
        first_lat = 0; done = 0; seen_e = 0; seen_f = 0;
        o_eaddr = '0; o_faddr = '0; o_waddr = '0;
        o_fblk = '0; o_wblk = '0; o_rblk = '0; o_rhit = 1'b0;
        while (!done && lat < 300) begin
            bus.evict_ack_i = 1'b0;
            bus.fill_done_i = 1'b0;
            bus.rsp_ready_i = 1'b0;
            if (bus.req_ready_o) ready_hi++;
            if (bus.tlt_rmen_o) begin
                n_rmen++;
                if (lat == 1) rmen1++;
            end
            if (bus.tlt_wren_o) begin
                n_wren++;
                o_wblk = bus.tlt_cache_addr_o;
                o_waddr = bus.tlt_addr_write_o;
            end
            if (bus.evict_req_o) begin
                if (!seen_e) begin
                    seen_e = 1;
                    o_eaddr = bus.evict_addr_o;
                end else if (bus.evict_addr_o !== o_eaddr) unstable++;
                if (ec == ew) bus.evict_ack_i = 1'b1;
                ec++;
            end
            if (bus.fill_req_o) begin
                if (!seen_f) begin
                    seen_f = 1;
                    o_faddr = bus.fill_addr_o;
                    o_fblk = bus.fill_cache_addr_o;
                end else if (bus.fill_addr_o !== o_faddr ||
                             bus.fill_cache_addr_o !== o_fblk) unstable++;
                if (fc == fw) bus.fill_done_i = 1'b1;
                fc++;
            end
            if (bus.rsp_valid_o) begin
                if (rc == 0) begin
                    first_lat = lat;
                    o_rhit = bus.rsp_hit_o;
                    o_rblk = bus.rsp_cache_addr_o;
                end else if (bus.rsp_hit_o !== o_rhit ||
                             bus.rsp_cache_addr_o !== o_rblk) unstable++;
                if (rc == rw) begin
                    bus.rsp_ready_i = 1'b1;
                    done = 1;
                end
                rc++;
            end
            tick();
            lat++;
        end
        bus.evict_ack_i = 1'b0;
        bus.fill_done_i = 1'b0;
        bus.rsp_ready_i = 1'b0;

        chk("rsp_seen", done, 1);
        chk("rsp_hit", o_rhit, ehit);
        chk("rsp_blk", o_rblk, eblk);
        chk("rsp_latency", first_lat, lat_exp);
        chk("rsp_cycles", rc, rw + 1);
        chk("evict_seen", seen_e, eev);
        chk("fill_seen", seen_f, !ehit);
        chk("rmen_lookup", rmen1, eev);
        chk("rmen_count", n_rmen, eev);
        chk("wren_count", n_wren, !ehit);
        chk("outputs_stable", unstable, 0);
        chk("req_ready_busy", ready_hi, 0);
        if (eev) chk("evict_addr", o_eaddr, eeaddr);
        if (!ehit) begin
            chk("fill_addr", o_faddr, base);
            chk("fill_blk", o_fblk, eblk);
            chk("wren_blk", o_wblk, eblk);
            chk("wren_addr", o_waddr, a);
        end
    endtask

    task automatic run_inv(input logic [AW-1:0] a, input bit with_req, input logic [AW-1:0] ra);
        bit ehit;
        int eblk, cyc;
        ehit = 0;
        eblk = 0;
        for (int i = 0; i < NB; i++)
            if (mv[i] && mt[i] == (a & 16'hfffc)) begin
                ehit = 1;
                eblk = i;
            end
        if (ehit) mv[eblk] = 0;

        bus.inv_addr_i = a;
        bus.inv_valid_i = 1'b1;
        if (with_req) begin
            bus.req_addr_i = ra;
            bus.req_valid_i = 1'b1;
        end
        #1;
        cyc = 0;
        while (bus.inv_ready_o !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("inv_ready", bus.inv_ready_o, 1);
        if (with_req) chk("req_ready_inv_prio", bus.req_ready_o, 0);
        tick();
        bus.inv_valid_i = 1'b0;
        chk("inv_rmen", bus.tlt_rmen_o, ehit);
        chk("inv_wren", bus.tlt_wren_o, 0);
        chk("inv_req_ready", bus.req_ready_o, 0);
        if (ehit) chk("inv_blk", bus.tlt_cache_addr_o, eblk);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        logic [AW-1:0] a;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.inv_valid_i = 1'b0;
        bus.inv_addr_i = '0;
        bus.evict_ack_i = 1'b0;
        bus.fill_done_i = 1'b0;
        model_reset();

        tick();
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_inv_ready", bus.inv_ready_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_fill_req", bus.fill_req_o, 0);
        chk("rst_evict_req", bus.evict_req_o, 0);
        chk("rst_wren", bus.tlt_wren_o, 0);
        chk("rst_search", bus.tlt_addr_search_o, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("release_ready_low", bus.req_ready_o, 0);
        tick();
        chk("ready_rise", bus.req_ready_o, 1);
        chk("inv_ready_rise", bus.inv_ready_o, 1);

        run_req(16'h0013, 0, 2, 0);
        run_req(16'h0011, 0, 0, 0);
        run_req(16'h0110, 0, 1, 1);
        run_req(16'h0210, 2, 1, 0);
        run_inv(16'h0110, 1, 16'h0110);
        run_req(16'h0110, 0, 0, 0);
        run_req(16'h0011, 1, 2, 5);

        // abandon a request mid-fill with reset
        bus.req_addr_i = 16'h0510;
        bus.req_valid_i = 1'b1;
        chk("mid_req_ready", bus.req_ready_o, 1);
        tick();
        bus.req_valid_i = 1'b0;
        cyc = 0;
        while (bus.fill_req_o !== 1'b1 && cyc < 20) begin
            bus.evict_ack_i = bus.evict_req_o;
            tick();
            cyc++;
        end
        bus.evict_ack_i = 1'b0;
        chk("fill_before_reset", bus.fill_req_o, 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_fill_drop", bus.fill_req_o, 0);
        chk("rst_fill_addr", bus.fill_addr_o, 0);
        chk("rst_no_rsp", bus.rsp_valid_o, 0);
        chk("rst_mid_ready", bus.req_ready_o, 0);
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        chk("ready_after_mid_rst", bus.req_ready_o, 1);
        run_req(16'h0210, 0, 1, 0);

        for (int n = 0; n < 60; n++) begin
            a = AW'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2) |
                    $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0)
                run_inv(a, 0, '0);
            else
                run_req(a, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
